// File: rtl/hga_ahb_pkg.sv
// rtl/hga_ahb_pkg.sv - shared AHB encodings and arbiter state type
package hga_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NSEQ   = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;

   // data access, privileged, non-bufferable, non-cacheable
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWN   = 2'd1,
      ARB_DRAIN = 2'd2
   } arb_state_t;

   // a transfer occupies a data phase unless it is IDLE or BUSY
   function automatic logic htrans_has_data(input logic [1:0] t);
      return (t == HTRANS_NSEQ) || (t == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector with optional master-0 priority
module rr_arbiter #(
   parameter int NM = 3,
   parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] ptr,
   input  logic          hipri_en,
   output logic [NM-1:0] gnt,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // master 0 wins outright when priority is on, otherwise scan starting just after ptr
   always_comb begin
      int j;
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      if (hipri_en && req[0]) begin
         gnt[0] = 1'b1;
         valid  = 1'b1;
      end else begin
         for (int k = 1; k <= NM; k++) begin
            j = (int'(ptr) + k) % NM;
            if (!valid && req[j]) begin
               valid  = 1'b1;
               gnt[j] = 1'b1;
               idx    = IW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - shares one AHB master port between NM requesters
module ahb_master_arbiter
   import hga_ahb_pkg::*;
#(
   parameter int NM       = 3,
   parameter int HIPRI_EN = 1,
   parameter int AW       = 64,
   parameter int DW       = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NM-1:0]   m_req,
   output logic [NM-1:0]   m_ack,
   input  logic [NM*AW-1:0] m_haddr,
   input  logic [NM-1:0]   m_hwrite,
   input  logic [NM*3-1:0] m_hsize,
   input  logic [NM*3-1:0] m_hburst,
   input  logic [NM*2-1:0] m_htrans,
   input  logic [NM*DW-1:0] m_hwdata,
   output logic [NM-1:0]   m_hready,
   output logic [NM-1:0]   m_hresp,
   output logic [AW-1:0]   haddr,
   output logic            hwrite,
   output logic [2:0]      hsize,
   output logic [2:0]      hburst,
   output logic [1:0]      htrans,
   output logic [DW-1:0]   hwdata,
   output logic [3:0]      hprot,
   output logic            hmastlock,
   input  logic            hready,
   input  logic            hresp
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;

   arb_state_t      state, state_nxt;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   rr_ptr;
   logic [NM-1:0]   ack_q;
   logic            data_valid;
   logic [IW-1:0]   data_owner;

   logic [NM-1:0]   sel_gnt;
   logic [IW-1:0]   sel_idx;
   logic            sel_valid;

   logic [AW-1:0]   own_haddr, haddr_q;
   logic            own_hwrite, hwrite_q;
   logic [2:0]      own_hsize, hsize_q;
   logic [2:0]      own_hburst, hburst_q;
   logic [1:0]      own_htrans;
   logic [DW-1:0]   dph_hwdata, hwdata_q;
   logic            in_own;

   rr_arbiter #(.NM(NM), .IW(IW)) u_rr (
      .req      (m_req),
      .ptr      (rr_ptr),
      .hipri_en (HIPRI_EN != 0),
      .gnt      (sel_gnt),
      .idx      (sel_idx),
      .valid    (sel_valid)
   );

   assign in_own = (state == ARB_OWN);

   // select the address-phase owner's signals and the data-phase owner's write data
   always_comb begin
      own_haddr  = m_haddr [int'(owner)*AW +: AW];
      own_hwrite = m_hwrite[owner];
      own_hsize  = m_hsize [int'(owner)*3 +: 3];
      own_hburst = m_hburst[int'(owner)*3 +: 3];
      own_htrans = m_htrans[int'(owner)*2 +: 2];
      dph_hwdata = m_hwdata[int'(data_owner)*DW +: DW];
   end

   // arbitration FSM state register and winner bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ARB_IDLE;
         owner  <= '0;
         rr_ptr <= IW'(NM-1);
         ack_q  <= '0;
      end else begin
         state <= state_nxt;
         if (state == ARB_IDLE && sel_valid) begin
            owner  <= sel_idx;
            rr_ptr <= sel_idx;
            ack_q  <= sel_gnt;
         end
      end
   end

   // next state: grant from IDLE, hold until owner drops, drain the last data phase
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:  if (sel_valid)     state_nxt = ARB_OWN;
         ARB_OWN:   if (!m_req[owner]) state_nxt = ARB_DRAIN;
         ARB_DRAIN: if (hready)        state_nxt = ARB_IDLE;
         default:                      state_nxt = ARB_IDLE;
      endcase
   end

   // data phase tracking: advances only on hready, follows the address phase just accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_valid <= 1'b0;
         data_owner <= '0;
      end else if (hready) begin
         data_valid <= htrans_has_data(htrans);
         data_owner <= owner;
      end
   end

   // remember last driven address-phase and write-data values so the bus holds them when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hsize_q  <= '0;
         hburst_q <= '0;
         hwdata_q <= '0;
      end else begin
         if (in_own) begin
            haddr_q  <= own_haddr;
            hwrite_q <= own_hwrite;
            hsize_q  <= own_hsize;
            hburst_q <= own_hburst;
         end
         if (data_valid) begin
            hwdata_q <= dph_hwdata;
         end
      end
   end

   // AHB master outputs: owner pass-through while granted, IDLE with held address otherwise
   always_comb begin
      m_ack     = in_own ? ack_q : '0;
      haddr     = in_own ? own_haddr  : haddr_q;
      hwrite    = in_own ? own_hwrite : hwrite_q;
      hsize     = in_own ? own_hsize  : hsize_q;
      hburst    = in_own ? own_hburst : hburst_q;
      htrans    = in_own ? own_htrans : HTRANS_IDLE;
      hwdata    = data_valid ? dph_hwdata : hwdata_q;
      hprot     = HPROT_DEFAULT;
      hmastlock = 1'b0;
   end

   // route hready to address or data owner and hresp to the data owner only
   always_comb begin
      m_hready = '0;
      m_hresp  = '0;
      for (int i = 0; i < NM; i++) begin
         m_hready[i] = hready & ((in_own && owner == IW'(i)) ||
                                 (data_valid && data_owner == IW'(i)));
         m_hresp[i]  = hresp & data_valid & (data_owner == IW'(i));
      end
   end

endmodule
